// File: rtl/scanner_rx.sv
// Receive side of the scanner serial link: LSB-first deserializer, command decode, sticky flags.
// Optional frame timeout is compiled in with `define SCANNER_RX_TIMEOUT_EN.
module scanner_rx #(
  parameter logic [7:0] DATA_CMD = 8'd7,
  parameter int         TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clkIn,
  input  logic       dataIn,
  input  logic       clrFlags,
  output logic [1:0] ps,
  output logic       cmdValid,
  output logic [7:0] cmdCode,
  output logic       dataValid,
  output logic [7:0] dataByte,
  output logic       readyFlag,
  output logic       startFlag,
  output logic       fullFlag,
  output logic       cmdErr,
  output logic       timeoutErr
);

  typedef enum logic [1:0] {
    CMD  = 2'b00,
    DATA = 2'b01
  } state_e;

  state_e     state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic [7:0] cmd_code_q;
  logic [7:0] data_byte_q;
  logic       ready_q;
  logic       start_q;
  logic       full_q;
  logic       cmd_valid_q;
  logic       data_valid_q;
  logic       cmd_err_q;
  logic       timeout_err_q;

  logic       byte_done;
  logic [7:0] byte_d;
  logic       timeout_hit;

  // The 8th bit goes straight into the decoded byte instead of waiting a cycle in shift_q.
  assign byte_done = clkIn && (bit_cnt_q == 3'd7);
  assign byte_d    = {dataIn, shift_q[6:0]};

`ifdef SCANNER_RX_TIMEOUT_EN
  logic [7:0] idle_q;
  logic       idle_active;

  assign idle_active = (bit_cnt_q != 3'd0) || (state_q == DATA);
  assign timeout_hit = !clkIn && idle_active && (idle_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= 8'd0;
    end else if (clkIn || timeout_hit || !idle_active) begin
      idle_q <= 8'd0;
    end else begin
      idle_q <= idle_q + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= CMD;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'd0;
      cmd_code_q    <= 8'd0;
      data_byte_q   <= 8'd0;
      ready_q       <= 1'b0;
      start_q       <= 1'b0;
      full_q        <= 1'b0;
      cmd_valid_q   <= 1'b0;
      data_valid_q  <= 1'b0;
      cmd_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      cmd_valid_q   <= 1'b0;
      data_valid_q  <= 1'b0;
      cmd_err_q     <= 1'b0;
      timeout_err_q <= timeout_hit;
      // Clear first so a same-cycle set below overrides it.
      if (clrFlags) begin
        ready_q <= 1'b0;
        start_q <= 1'b0;
        full_q  <= 1'b0;
      end
      if (clkIn) begin
        shift_q[bit_cnt_q] <= dataIn;
        bit_cnt_q          <= bit_cnt_q + 3'd1;
        if (byte_done) begin
          if (state_q == CMD) begin
            cmd_code_q  <= byte_d;
            cmd_valid_q <= 1'b1;
            if (byte_d == DATA_CMD) begin
              state_q <= DATA;
            end else if (byte_d == 8'd2) begin
              ready_q <= 1'b1;
            end else if (byte_d == 8'd3) begin
              start_q <= 1'b1;
            end else if (byte_d == 8'd4) begin
              full_q <= 1'b1;
            end else begin
              cmd_err_q <= 1'b1;
            end
          end else begin
            data_byte_q  <= byte_d;
            data_valid_q <= 1'b1;
            full_q       <= 1'b0;
            state_q      <= CMD;
          end
        end
      end else if (timeout_hit) begin
        bit_cnt_q <= 3'd0;
        shift_q   <= 8'd0;
        state_q   <= CMD;
      end
    end
  end

  assign ps         = state_q;
  assign cmdValid   = cmd_valid_q;
  assign cmdCode    = cmd_code_q;
  assign dataValid  = data_valid_q;
  assign dataByte   = data_byte_q;
  assign readyFlag  = ready_q;
  assign startFlag  = start_q;
  assign fullFlag   = full_q;
  assign cmdErr     = cmd_err_q;
  assign timeoutErr = timeout_err_q;

endmodule

// File: tb/tb_scanner_rx.sv
// Directed bench for scanner_rx: expected frames are queued as bits are driven and
// checked when cmdValid/dataValid fire; flags and state are checked between steps.
module tb_scanner_rx;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       clkIn;
  logic       dataIn;
  logic       clrFlags;
  logic [1:0] ps;
  logic       cmdValid;
  logic [7:0] cmdCode;
  logic       dataValid;
  logic [7:0] dataByte;
  logic       readyFlag;
  logic       startFlag;
  logic       fullFlag;
  logic       cmdErr;
  logic       timeoutErr;

  always #5 clk = ~clk;

  scanner_rx #(.DATA_CMD(8'd7), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .clkIn     (clkIn),
    .dataIn    (dataIn),
    .clrFlags  (clrFlags),
    .ps        (ps),
    .cmdValid  (cmdValid),
    .cmdCode   (cmdCode),
    .dataValid (dataValid),
    .dataByte  (dataByte),
    .readyFlag (readyFlag),
    .startFlag (startFlag),
    .fullFlag  (fullFlag),
    .cmdErr    (cmdErr),
    .timeoutErr(timeoutErr)
  );

  typedef struct packed {
    logic       is_data;
    logic [7:0] val;
    logic       err;
    logic [1:0] ps;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   tmo_seen = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    checks++;
    assert (obs === want)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic push(input logic is_data, input logic [7:0] val, input logic err,
                      input logic [1:0] nps);
    exp_t e;
    e.is_data = is_data;
    e.val     = val;
    e.err     = err;
    e.ps      = nps;
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clkIn  = 1'b1;
      dataIn = b[i];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clkIn  = 1'b0;
      dataIn = 1'b0;
    end
  endtask

  // Output monitor: every completion pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (timeoutErr) tmo_seen++;
    if (cmdValid || dataValid) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 8'(sb.size()), 8'd1);
      end else begin
        e = sb.pop_front();
        chk("out_kind", {6'd0, cmdValid, dataValid}, e.is_data ? 8'd1 : 8'd2);
        chk("out_byte", e.is_data ? dataByte : cmdCode, e.val);
        chk("out_err", {7'd0, cmdErr}, {7'd0, e.err});
        chk("out_ps", {6'd0, ps}, {6'd0, e.ps});
      end
    end else if (cmdErr) begin
      chk("stray_err", {7'd0, cmdErr}, 8'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    clkIn    = 1'b0;
    dataIn   = 1'b0;
    clrFlags = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ps", {6'd0, ps}, 8'd0);
    chk("rst_cmdCode", cmdCode, 8'd0);
    chk("rst_dataByte", dataByte, 8'd0);
    chk("rst_outs", {1'b0, readyFlag, startFlag, fullFlag, cmdValid, dataValid, cmdErr,
                     timeoutErr}, 8'd0);
    rst = 1'b0;

    // Ready command
    push(1'b0, 8'h02, 1'b0, 2'b00);
    send(8'h02, 8);
    idle(2);
    chk("ready_set", {7'd0, readyFlag}, 8'd1);
    chk("ready_ps", {6'd0, ps}, 8'd0);

    // Data command followed back-to-back by payload
    push(1'b0, 8'h07, 1'b0, 2'b01);
    push(1'b1, 8'hA5, 1'b0, 2'b00);
    send(8'h07, 8);
    send(8'hA5, 8);
    idle(2);
    chk("a5_dataByte", dataByte, 8'hA5);

    // Full flag set by command 4, cleared by the next payload
    push(1'b0, 8'h04, 1'b0, 2'b00);
    send(8'h04, 8);
    idle(2);
    chk("full_set", {7'd0, fullFlag}, 8'd1);
    push(1'b0, 8'h07, 1'b0, 2'b01);
    push(1'b1, 8'h3C, 1'b0, 2'b00);
    send(8'h07, 8);
    send(8'h3C, 8);
    idle(2);
    chk("full_clr", {7'd0, fullFlag}, 8'd0);
    chk("3c_dataByte", dataByte, 8'h3C);
    chk("ready_kept", {7'd0, readyFlag}, 8'd1);

    // Unknown command: error pulse, flags untouched
    push(1'b0, 8'h09, 1'b1, 2'b00);
    send(8'h09, 8);
    idle(2);
    chk("err_flags", {5'd0, readyFlag, startFlag, fullFlag}, 8'b100);

    // clrFlags on the completing strobe of command 3: start set wins, ready cleared
    push(1'b0, 8'h03, 1'b0, 2'b00);
    send(8'h03, 7);
    @(negedge clk);
    clkIn    = 1'b1;
    dataIn   = 1'b0;
    clrFlags = 1'b1;
    @(negedge clk);
    clkIn    = 1'b0;
    clrFlags = 1'b0;
    idle(1);
    chk("clr_vs_set", {5'd0, readyFlag, startFlag, fullFlag}, 8'b010);
    @(negedge clk);
    clrFlags = 1'b1;
    @(negedge clk);
    clrFlags = 1'b0;
    chk("clr_only", {5'd0, readyFlag, startFlag, fullFlag}, 8'b000);

    // Partial frame followed by a long gap, then a full command 3
    send(8'h03, 5);
    idle(TIMEOUT);
    idle(2);
`ifdef SCANNER_RX_TIMEOUT_EN
    chk("tmo_pulse", 8'(tmo_seen), 8'd1);
    chk("tmo_flags", {5'd0, readyFlag, startFlag, fullFlag}, 8'b000);
    push(1'b0, 8'h03, 1'b0, 2'b00);
    send(8'h03, 8);
    idle(2);
    chk("tmo_start", {7'd0, startFlag}, 8'd1);
`else
    chk("tmo_none", 8'(tmo_seen), 8'd0);
    push(1'b0, 8'h63, 1'b1, 2'b00);
    send(8'h03, 8);
    idle(2);
    chk("misalign_start", {7'd0, startFlag}, 8'd0);
`endif

    // Reset in the middle of a payload
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push(1'b0, 8'h02, 1'b0, 2'b00);
    push(1'b0, 8'h07, 1'b0, 2'b01);
    send(8'h02, 8);
    send(8'h07, 8);
    send(8'hA5, 4);
    @(negedge clk);
    clkIn = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ps", {6'd0, ps}, 8'd0);
    chk("rst_mid_flags", {5'd0, readyFlag, startFlag, fullFlag}, 8'b000);
    push(1'b0, 8'h03, 1'b0, 2'b00);
    send(8'h03, 8);
    idle(2);
    chk("post_rst_start", {7'd0, startFlag}, 8'd1);
    chk("post_rst_ps", {6'd0, ps}, 8'd0);

    idle(4);
    chk("sb_drained", 8'(sb.size()), 8'd0);
`ifdef SCANNER_RX_TIMEOUT_EN
    chk("tmo_total", 8'(tmo_seen), 8'd1);
`else
    chk("tmo_total", 8'(tmo_seen), 8'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/scanner_rx.md
# scanner_rx

Receive end of the scanner's serial command/data link. Deserializes the bit-strobed, LSB-first stream from the scanner's `clkOut`/`dataOut` pins into command bytes and data payload bytes. Decodes the command set into one-cycle pulses and sticky status flags. Sits on the host/output-driver side, in the same clock domain as the scanner.

## Interface
Parameters:
- `DATA_CMD`, 8'd7: command code announcing that one data byte follows.
- `TIMEOUT`, 16: consecutive idle-strobe cycles before a partial frame is discarded (used only with `SCANNER_RX_TIMEOUT_EN`); legal range 2..255.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `clkIn`  in  1  bit strobe from the scanner; `dataIn` is valid in each cycle where this is 1.
- `dataIn`  in  1  serial bit, LSB first.
- `clrFlags`  in  1  one-cycle clear of all sticky status flags.
- `ps`  out  2  present state (CMD=2'b00, DATA=2'b01).
- `cmdValid`  out  1  one-cycle pulse; `cmdCode` holds a completed command byte.
- `cmdCode`  out  8  last command byte received.
- `dataValid`  out  1  one-cycle pulse; `dataByte` holds a payload byte.
- `dataByte`  out  8  last payload byte received.
- `readyFlag`, `startFlag`, `fullFlag`  out  1 each  sticky flags set by commands 2, 3 and 4 respectively.
- `cmdErr`  out  1  one-cycle pulse on an unrecognized command code.
- `timeoutErr`  out  1  one-cycle pulse on a frame timeout.

## Operation
- Reset values: `ps`=CMD, `cmdCode`=0, `dataByte`=0, all flags 0, all pulses 0. Bit counter, shift register and idle counter are also 0.
- Bit capture: on each `clk` edge with `clkIn`=1, shift `dataIn` into `shift[bitCnt]` and increment the 3-bit `bitCnt`. The first bit received is bit 0.
- Byte completes on the 8th strobe, when `bitCnt` wraps 7→0.
- CMD state, byte complete:
  - Load `cmdCode` and pulse `cmdValid`.
  - Code 2 sets `readyFlag`; 3 sets `startFlag`; 4 sets `fullFlag`.
  - Code `DATA_CMD` moves to DATA.
  - Any other code pulses `cmdErr` and stays in CMD (`cmdValid` still pulses).
- DATA state, byte complete: load `dataByte`, pulse `dataValid`, clear `fullFlag`, return to CMD.
- `clrFlags` clears all three flags. If a set and `clrFlags` occur in the same cycle, the set wins.
- Back-to-back bytes: a strobe in the cycle right after a byte completes is bit 0 of the next byte. No gap is required and no bits are lost.
- Gaps between strobes within a byte are allowed (`clkIn` may drop for any number of cycles unless the timeout is enabled).
- `rst` mid-byte or in DATA: partial byte is discarded, state returns to CMD, flags clear.

## Timing
- Latency: 8th strobe sampled at edge N; `cmdValid`/`dataValid`/`cmdErr` are high for the cycle after edge N only. `cmdCode`/`dataByte` are valid from edge N and held until the next completion.
- Flags update at edge N (same edge as the code load).
- `ps` changes at edge N.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `SCANNER_RX_TIMEOUT_EN` defined:
  - Idle counter increments on each cycle with `clkIn`=0 while `bitCnt`≠0 or `ps`=DATA; it resets to 0 on any strobe.
  - When the counter reaches `TIMEOUT`: discard the partial byte, `bitCnt`=0, `ps`=CMD, pulse `timeoutErr` for one cycle. Flags are unchanged.
  - A strobe arriving in the cycle the count hits `TIMEOUT` wins: it is captured and no timeout occurs.
- Not defined: no idle counter; partial frames are held indefinitely; `timeoutErr` is tied 0.

## Test plan
- Reset, then serialize 8'h02 LSB-first with 8 consecutive strobes → `cmdValid` pulses 1 cycle after the 8th strobe, `cmdCode`=8'h02, `readyFlag`=1, `ps` stays 00.
- Send 8'h07 then 8'hA5 back-to-back (16 consecutive strobes) → `cmdValid` with `cmdCode`=8'h07 and `ps`=01; then `dataValid` with `dataByte`=8'hA5 and `ps`=00.
- Send 8'h04, then 8'h07 + 8'h3C → `fullFlag`=1 after 8'h04 and 0 after the payload; `dataByte`=8'h3C.
- Send 8'h09 → `cmdValid` and `cmdErr` both pulse; flags unchanged; `ps`=00.
- Send 5 bits of 8'h03, hold `clkIn`=0 for `TIMEOUT` cycles, then send full 8'h03:
  - With macro: `timeoutErr` pulses, then `cmdCode`=8'h03 and `startFlag`=1.
  - Without macro: no error; the bytes misalign.
- Assert `rst` after 4 bits of the payload following 8'h07 → `ps`=00 and flags 0. A subsequent 8'h03 decodes as a command.
